// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC sample buffer with SPI readout.
// The header byte layout lives here so the RTL and any consumer agree on it.
package adc_pkg;

    localparam int SAMPLE_W    = 8;
    localparam int HDR_OVF_BIT = 7;
    localparam int HDR_CNT_W   = 7;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } spi_state_t;

    function automatic logic [SAMPLE_W-1:0] make_header(input logic ovf,
                                                        input logic [HDR_CNT_W-1:0] cnt);
        logic [SAMPLE_W-1:0] hdr;
        hdr              = '0;
        hdr[HDR_OVF_BIT] = ovf;
        hdr[HDR_CNT_W-1:0] = cnt;
        return hdr;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous level, followed by a
// single-cycle rise/fall detector on the synchronized value.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
        rise   = sync_q[STAGES-1] & ~prev_q;
        fall   = ~sync_q[STAGES-1] & prev_q;
    end

    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/adc_sample_spi.sv
// Sample FIFO fed by the ADC interface and drained by a mode-0 SPI slave.
// Every transaction starts with a {overflow, count} header, then FIFO bytes.
module adc_sample_spi import adc_pkg::*; #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     osc_clk,
    input  logic                     reset,
    input  logic                     write_enable,
    input  logic [SAMPLE_W-1:0]      write_data,
    input  logic                     sck,
    input  logic                     cs_n,
    output logic                     miso,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic we_rise, we_fall_unused, sck_rise_unused, sck_fall, cs_rise, cs_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_we_sync (
        .clk(osc_clk), .rst_n(reset), .d(write_enable), .rise(we_rise), .fall(we_fall_unused)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(osc_clk), .rst_n(reset), .d(sck), .rise(sck_rise_unused), .fall(sck_fall)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(osc_clk), .rst_n(reset), .d(cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    spi_state_t          state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [SAMPLE_W-1:0] tx_q, tx_d;
    logic [SAMPLE_W-1:0] cap_data_q, cap_data_d;
    logic                cap_valid_q, cap_valid_d;
    logic                miso_q, miso_d;
    logic                ovf_q, ovf_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [SAMPLE_W-1:0] mem_q [DEPTH];
    logic                full, empty, hdr_load, byte_done, push, pop, drop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
    always_comb begin
        full      = (count_q == CNT_W'(DEPTH));
        empty     = (count_q == '0);
        hdr_load  = (state_q == IDLE) && cs_fall;
        byte_done = (state_q != IDLE) && !cs_rise && sck_fall && (bit_cnt_q == 3'd7);
        pop       = byte_done && !empty;
        push      = cap_valid_q && (!full || pop);
        drop      = cap_valid_q && full && !pop;
    end

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        cap_valid_d = we_rise;
        cap_data_d  = we_rise ? write_data : cap_data_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop) count_d = count_q + CNT_W'(1);
        if (pop && !push) count_d = count_q - CNT_W'(1);

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        ovf_d     = ovf_q;
        if (cs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
        end else if (hdr_load) begin
            state_d   = HEADER;
            bit_cnt_d = '0;
            tx_d      = make_header(ovf_q, HDR_CNT_W'(count_q));
            ovf_d     = 1'b0;
        end else if ((state_q != IDLE) && sck_fall) begin
            if (byte_done) begin
                state_d   = DATA;
                bit_cnt_d = '0;
                tx_d      = pop ? mem_q[rd_ptr_q] : '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                tx_d      = {tx_q[SAMPLE_W-2:0], 1'b0};
            end
        end
        // A drop in the header-load cycle must survive the clear.
        if (drop) ovf_d = 1'b1;

        miso_d = (state_q != IDLE) && tx_q[SAMPLE_W-1];
    end

    always_ff @(posedge osc_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
            miso_q      <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
            miso_q      <= miso_d;
            ovf_q       <= ovf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide what is valid.
    always_ff @(posedge osc_clk) begin
        if (push) mem_q[wr_ptr_q] <= cap_data_q;
    end

    assign miso       = miso_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_sample_spi.sv
// Randomized bench for adc_sample_spi: an SPI master collects bytes, a monitor
// compares them against a queue filled from a sample-level reference model.
`timescale 1ns/1ps
module tb_adc_sample_spi;

    localparam int DEPTH = 16;
    localparam int HALF  = 8;   // osc_clk cycles per sck half period

    logic       osc_clk = 1'b0;
    logic       reset;
    logic       write_enable;
    logic [7:0] write_data;
    logic       sck;
    logic       cs_n;
    logic       miso;
    logic [4:0] fifo_count;
    logic       overflow;

    adc_sample_spi #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .osc_clk(osc_clk), .reset(reset), .write_enable(write_enable),
        .write_data(write_data), .sck(sck), .cs_n(cs_n), .miso(miso),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 osc_clk = ~osc_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    logic       ovf_after_cs;
    event       rx_ev;
    event       byte_fall_ev;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a bounded queue of samples plus a sticky drop flag.
    function automatic void model_push(input logic [7:0] v);
        if (model_q.size() < DEPTH) model_q.push_back(v);
        else model_ovf = 1'b1;
    endfunction

    function automatic logic [7:0] model_header();
        logic [7:0] h;
        h = {model_ovf, 7'(model_q.size())};
        model_ovf = 1'b0;
        return h;
    endfunction

    function automatic logic [7:0] model_load();
        if (model_q.size() == 0) return 8'h00;
        return model_q.pop_front();
    endfunction

    // Each completed byte ends with a reload; the last reload is never shifted out.
    function automatic void expect_xfer(input int n_full);
        logic [7:0] v;
        v = model_header();
        if (n_full > 0) exp_q.push_back(v);
        for (int i = 1; i <= n_full; i++) begin
            v = model_load();
            if (i < n_full) exp_q.push_back(v);
        end
    endfunction

    task automatic pulse(input logic [7:0] v);
        @(negedge osc_clk);
        write_data   = v;
        write_enable = 1'b1;
        repeat (6) @(negedge osc_clk);
        write_enable = 1'b0;
        repeat (6) @(negedge osc_clk);
    endtask

    task automatic push_sample(input logic [7:0] v);
        model_push(v);
        pulse(v);
    endtask

    task automatic spi_xfer(input int n_full, input int extra_bits);
        logic [7:0] sh;
        sh = '0;
        @(negedge osc_clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge osc_clk);
        ovf_after_cs = overflow;
        for (int b = 0; b <= n_full; b++) begin
            int nbits;
            nbits = (b < n_full) ? 8 : extra_bits;
            for (int i = 0; i < nbits; i++) begin
                sck = 1'b1;
                sh  = {sh[6:0], miso};
                repeat (HALF) @(negedge osc_clk);
                sck = 1'b0;
                if (i == 7) -> byte_fall_ev;
                repeat (HALF) @(negedge osc_clk);
            end
            if (b < n_full) begin
                rx_q.push_back(sh);
                -> rx_ev;
            end
        end
        cs_n = 1'b1;
        repeat (12) @(negedge osc_clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
        check({tag, "_ovf"}, 32'(overflow), 32'(model_ovf));
    endtask

    // Monitor: every byte the master assembles is compared with the next expectation.
    initial begin
        logic [7:0] got;
        forever begin
            @(rx_ev);
            while (rx_q.size() > 0) begin
                got = rx_q.pop_front();
                if (exp_q.size() == 0) check("spi_byte_unexpected", 32'(got), 32'h100);
                else check("spi_byte", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] newv, v;
        int total;

        // Reset with random activity on every input.
        reset = 1'b0; write_enable = 1'b0; write_data = '0; sck = 1'b0; cs_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge osc_clk);
            write_enable = 1'($urandom); write_data = 8'($urandom);
            sck = 1'($urandom); cs_n = 1'($urandom);
        end
        check("rst_miso", 32'(miso), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        write_enable = 1'b0; sck = 1'b0; cs_n = 1'b1;
        repeat (5) @(negedge osc_clk);
        reset = 1'b1;
        repeat (10) @(negedge osc_clk);
        check_state("post_rst");
        check("post_rst_miso", 32'(miso), 32'd0);

        // Capture three samples, then read header plus all three.
        push_sample(8'h5A); push_sample(8'hC3); push_sample(8'h01);
        check_state("capture");
        expect_xfer(4);
        spi_xfer(4, 0);
        check_state("capture_read");
        check("idle_miso", 32'(miso), 32'd0);

        // Overflow: 17 pushes into 16 slots.
        for (int i = 0; i < 17; i++) push_sample(8'($urandom));
        check_state("ovf_fill");
        expect_xfer(17);
        spi_xfer(17, 0);
        check("ovf_clr_at_cs", 32'(ovf_after_cs), 32'd0);
        check_state("ovf_read");

        // Empty read.
        expect_xfer(3);
        spi_xfer(3, 0);
        check_state("empty_read");

        // Push aligned with the first data reload while full.
        for (int i = 0; i < 16; i++) push_sample(8'($urandom));
        check_state("simul_fill");
        newv = 8'($urandom);
        exp_q.push_back(model_header());
        exp_q.push_back(model_load());
        model_push(newv);
        for (int i = 2; i <= 18; i++) begin
            v = model_load();
            if (i < 18) exp_q.push_back(v);
        end
        fork
            spi_xfer(18, 0);
            begin
                @(byte_fall_ev);
                @(negedge osc_clk);
                pulse(newv);
                check("simul_count", 32'(fifo_count), 32'd16);
                check("simul_ovf", 32'(overflow), 32'd0);
            end
        join
        check_state("simul_read");

        // Abort after four bits of the first data byte: that sample is lost.
        push_sample(8'hA1); push_sample(8'hB2); push_sample(8'hC4);
        expect_xfer(1);
        spi_xfer(1, 4);
        check_state("abort");
        expect_xfer(3);
        spi_xfer(3, 0);
        check_state("abort_read");

        // Random rounds across pointer wrap.
        total = 0;
        while (total < 40) begin
            int k, n;
            k = $urandom_range(1, 5);
            for (int i = 0; i < k; i++) push_sample(8'($urandom));
            total += k;
            check_state("wrap_push");
            n = $urandom_range(1, 6);
            expect_xfer(n);
            spi_xfer(n, 0);
            check_state("wrap_read");
        end
        expect_xfer(18);
        spi_xfer(18, 0);
        check_state("final_drain");

        repeat (20) @(negedge osc_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
